// File: rtl/pipe_pkg.sv
// Shared constants, ALU opcodes and multiplier state encoding for the 8-bit pipeline.
package pipe_pkg;
  localparam int DATA_W     = 8;
  localparam int REG_W      = 3;
  localparam int PC_W       = 8;
  localparam int MUL_CYCLES = DATA_W;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;
endpackage

// File: rtl/ex_mul_unit.sv
// Shift-add multiplier: captures operands in E0, iterates MUL_CYCLES times, presents the
// low DATA_W bits of the product for one DONE cycle. A flush returns it to IDLE.
module ex_mul_unit #(
  parameter int DATA_W     = pipe_pkg::DATA_W,
  parameter int MUL_CYCLES = pipe_pkg::MUL_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  import pipe_pkg::*;

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_e        state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state and datapath update; the forwarded operands are only sampled in IDLE.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy     = 1'b1;
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign product = acc_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX latch, WB->EX operand forwarding, single-cycle ALU and a
// stalling multi-cycle multiplier. Outputs are combinational from the latch and multiplier.
module ex_stage #(
  parameter int DATA_W     = pipe_pkg::DATA_W,
  parameter int REG_W      = pipe_pkg::REG_W,
  parameter int MUL_CYCLES = pipe_pkg::MUL_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Flush_EX,
  input  logic [pipe_pkg::PC_W-1:0] PC_ID,
  input  logic                   RegWrite_ID,
  input  logic [2:0]             ALUOp_ID,
  input  logic [DATA_W-1:0]      ReadData1_ID,
  input  logic [DATA_W-1:0]      ReadData2_ID,
  input  logic [REG_W-1:0]       Read_Reg1_ID,
  input  logic [REG_W-1:0]       Read_Reg2_ID,
  input  logic [REG_W-1:0]       Write_Reg_ID,
  input  logic                   RegWrite_WB,
  input  logic [REG_W-1:0]       Write_Reg_WB,
  input  logic [DATA_W-1:0]      Result_WB,
  output logic [pipe_pkg::PC_W-1:0] PC_EX,
  output logic                   RegWrite_EX,
  output logic [DATA_W-1:0]      Result_EX,
  output logic [REG_W-1:0]       Write_Reg_EX,
  output logic                   Stall_EX
);
  import pipe_pkg::*;

  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic              rw_q, rw_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic [REG_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, wr_q, wr_d;

  logic [DATA_W-1:0] op_a, op_b, alu_res, mul_product;
  logic              mul_busy, mul_done;

  // Latch update: flush loads a bubble, a stall holds, otherwise take the ID instruction.
  always_comb begin
    pc_d  = pc_q;
    rw_d  = rw_q;
    op_d  = op_q;
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    wr_d  = wr_q;
    if (Flush_EX) begin
      pc_d  = '0;
      rw_d  = 1'b0;
      op_d  = ALU_ADD;
      rd1_d = '0;
      rd2_d = '0;
      rs1_d = '0;
      rs2_d = '0;
      wr_d  = '0;
    end else if (!Stall_EX) begin
      pc_d  = PC_ID;
      rw_d  = RegWrite_ID;
      op_d  = ALUOp_ID;
      rd1_d = ReadData1_ID;
      rd2_d = ReadData2_ID;
      rs1_d = Read_Reg1_ID;
      rs2_d = Read_Reg2_ID;
      wr_d  = Write_Reg_ID;
    end
  end

  // ID/EX latch; reset leaves an ADD bubble so the outputs read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      rw_q  <= 1'b0;
      op_q  <= ALU_ADD;
      rd1_q <= '0;
      rd2_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      wr_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      rw_q  <= rw_d;
      op_q  <= op_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      wr_q  <= wr_d;
    end
  end

  // Forward the WB result onto stale operands; R0 is not special.
  assign op_a = (RegWrite_WB && (Write_Reg_WB == rs1_q)) ? Result_WB : rd1_q;
  assign op_b = (RegWrite_WB && (Write_Reg_WB == rs2_q)) ? Result_WB : rd2_q;

  ex_mul_unit #(
    .DATA_W    (DATA_W),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (op_q == ALU_MUL),
    .flush  (Flush_EX),
    .a      (op_a),
    .b      (op_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  // Single-cycle ALU; MUL selects the multiplier accumulator.
  always_comb begin
    alu_res = '0;
    case (op_q)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL: alu_res = op_a << op_b[SH_W-1:0];
      ALU_SRL: alu_res = op_a >> op_b[SH_W-1:0];
      ALU_MUL: alu_res = mul_product;
    endcase
  end

  assign Stall_EX     = mul_busy;
  assign RegWrite_EX  = rw_q && ((op_q != ALU_MUL) || mul_done);
  assign Result_EX    = alu_res;
  assign PC_EX        = pc_q;
  assign Write_Reg_EX = wr_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against an arithmetic reference model.
module tb_ex_stage;
  import pipe_pkg::*;

  typedef struct {
    logic [7:0] pc;
    logic       rw;
    logic [2:0] op;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] wr;
  } instr_t;

  logic       clk = 1'b0;
  logic       reset, Flush_EX;
  logic [7:0] PC_ID;
  logic       RegWrite_ID;
  logic [2:0] ALUOp_ID;
  logic [7:0] ReadData1_ID, ReadData2_ID;
  logic [2:0] Read_Reg1_ID, Read_Reg2_ID, Write_Reg_ID;
  logic       RegWrite_WB;
  logic [2:0] Write_Reg_WB;
  logic [7:0] Result_WB;
  logic [7:0] PC_EX;
  logic       RegWrite_EX;
  logic [7:0] Result_EX;
  logic [2:0] Write_Reg_EX;
  logic       Stall_EX;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .Flush_EX(Flush_EX),
    .PC_ID(PC_ID), .RegWrite_ID(RegWrite_ID), .ALUOp_ID(ALUOp_ID),
    .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID),
    .Read_Reg1_ID(Read_Reg1_ID), .Read_Reg2_ID(Read_Reg2_ID), .Write_Reg_ID(Write_Reg_ID),
    .RegWrite_WB(RegWrite_WB), .Write_Reg_WB(Write_Reg_WB), .Result_WB(Result_WB),
    .PC_EX(PC_EX), .RegWrite_EX(RegWrite_EX), .Result_EX(Result_EX),
    .Write_Reg_EX(Write_Reg_EX), .Stall_EX(Stall_EX)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic instr_t mk(input logic [7:0] pc, input logic rw, input logic [2:0] op,
                                input logic [7:0] d1, input logic [7:0] d2,
                                input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] wr);
    instr_t i;
    i.pc = pc; i.rw = rw; i.op = op; i.d1 = d1; i.d2 = d2; i.r1 = r1; i.r2 = r2; i.wr = wr;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    i.pc = 8'($urandom); i.rw = 1'($urandom); i.d1 = 8'($urandom); i.d2 = 8'($urandom);
    i.r1 = 3'($urandom); i.r2 = 3'($urandom); i.wr = 3'($urandom);
    i.op = ($urandom_range(0, 3) == 0) ? ALU_MUL : 3'($urandom_range(0, 6));
    return i;
  endfunction

  task automatic set_id(input instr_t i);
    PC_ID = i.pc; RegWrite_ID = i.rw; ALUOp_ID = i.op;
    ReadData1_ID = i.d1; ReadData2_ID = i.d2;
    Read_Reg1_ID = i.r1; Read_Reg2_ID = i.r2; Write_Reg_ID = i.wr;
  endtask

  task automatic set_wb(input logic rw, input logic [2:0] wr, input logic [7:0] res);
    RegWrite_WB = rw; Write_Reg_WB = wr; Result_WB = res;
  endtask

  // Reference: results are plain integer arithmetic reduced mod 256.
  function automatic logic [7:0] ref_alu(input logic [2:0] op, input int a, input int b);
    int r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b + 256;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a * (2 ** (b % 8));
      3'd6: r = a / (2 ** (b % 8));
      default: r = a * b;
    endcase
    return 8'(r % 256);
  endfunction

  // Instruction `c` is in EX (its first cycle); WB values apply to that first cycle only.
  // Ends one edge after c leaves EX, so whatever is on ID is then in EX.
  task automatic run_ex(input instr_t c, input logic wrw, input logic [2:0] wwr,
                        input logic [7:0] wres, input string tag);
    int a, b;
    logic [7:0] exp;
    set_wb(wrw, wwr, wres);
    a = (wrw && wwr == c.r1) ? int'(wres) : int'(c.d1);
    b = (wrw && wwr == c.r2) ? int'(wres) : int'(c.d2);
    exp = ref_alu(c.op, a, b);
    settle();
    if (c.op == ALU_MUL) begin
      for (int e = 0; e < 9; e++) begin
        chk({tag, " stall"}, Stall_EX, 1);
        chk({tag, " rw_while_stalled"}, RegWrite_EX, 0);
        step();
        set_wb(1'b1, c.r1, 8'($urandom));
        settle();
      end
    end
    chk({tag, " stall_clear"}, Stall_EX, 0);
    chk({tag, " result"}, Result_EX, exp);
    chk({tag, " regwrite"}, RegWrite_EX, c.rw);
    chk({tag, " pc"}, PC_EX, c.pc);
    chk({tag, " wreg"}, Write_Reg_EX, c.wr);
    step();
    set_wb(1'b0, 3'd0, 8'd0);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, " pc"}, PC_EX, 0);
    chk({tag, " regwrite"}, RegWrite_EX, 0);
    chk({tag, " result"}, Result_EX, 0);
    chk({tag, " wreg"}, Write_Reg_EX, 0);
    chk({tag, " stall"}, Stall_EX, 0);
  endtask

  initial begin
    instr_t cur, nxt;
    int mode;
    logic [2:0] wwr;

    // Reset for two edges with garbage on ID.
    reset = 1'b1; Flush_EX = 1'b0;
    set_wb(1'b0, 3'd0, 8'd0);
    set_id(mk(8'hA5, 1'b1, ALU_MUL, 8'h5A, 8'hC3, 3'd7, 3'd6, 3'd5));
    step(); step();
    settle();
    chk_bubble("reset");

    // ADD R1 = 3 + 4.
    cur = mk(8'h05, 1'b1, ALU_ADD, 8'd3, 8'd4, 3'd1, 3'd2, 3'd1);
    set_id(cur);
    reset = 1'b0;
    step();
    nxt = mk(8'h06, 1'b1, ALU_SUB, 8'h00, 8'h01, 3'd2, 3'd3, 3'd4);
    set_id(nxt);
    run_ex(cur, 1'b0, 3'd0, 8'd0, "add_first");

    // SUB with and without forwarding of R2 = 0x10.
    cur = nxt;
    nxt = mk(8'h07, 1'b1, ALU_SUB, 8'h00, 8'h01, 3'd2, 3'd3, 3'd4);
    set_id(nxt);
    run_ex(cur, 1'b1, 3'd2, 8'h10, "sub_fwd");
    cur = nxt;
    nxt = mk(8'h08, 1'b1, ALU_MUL, 8'd13, 8'd11, 3'd1, 3'd2, 3'd3);
    set_id(nxt);
    run_ex(cur, 1'b1, 3'd5, 8'h10, "sub_wrap");

    // MUL 13 * 11, then 0x20 * 0x10, then back-to-back 0xFF * 0xFF.
    cur = nxt;
    nxt = mk(8'h09, 1'b1, ALU_MUL, 8'h20, 8'h10, 3'd1, 3'd2, 3'd3);
    set_id(nxt);
    run_ex(cur, 1'b0, 3'd0, 8'd0, "mul_13x11");
    cur = nxt;
    nxt = mk(8'h0A, 1'b1, ALU_MUL, 8'hFF, 8'hFF, 3'd4, 3'd5, 3'd6);
    set_id(nxt);
    run_ex(cur, 1'b0, 3'd0, 8'd0, "mul_ovf");
    cur = nxt;
    nxt = mk(8'h0B, 1'b1, ALU_MUL, 8'd9, 8'd9, 3'd1, 3'd2, 3'd3);
    set_id(nxt);
    run_ex(cur, 1'b0, 3'd0, 8'd0, "mul_b2b");

    // nxt MUL is now in E0; flush it at E4.
    step(); step(); step(); step();
    settle();
    chk("flush_e4 stall_before", Stall_EX, 1);
    Flush_EX = 1'b1;
    cur = mk(8'h0C, 1'b1, ALU_ADD, 8'h21, 8'h12, 3'd1, 3'd2, 3'd7);
    set_id(cur);
    step();
    Flush_EX = 1'b0;
    settle();
    chk_bubble("flush_bubble");
    step();
    nxt = mk(8'h0D, 1'b1, ALU_MUL, 8'd3, 8'd5, 3'd1, 3'd2, 3'd3);
    set_id(nxt);
    run_ex(cur, 1'b0, 3'd0, 8'd0, "add_after_flush");

    // nxt MUL in E0 with stall high: flush wins over the stall.
    settle();
    chk("stall_flush stall", Stall_EX, 1);
    Flush_EX = 1'b1;
    cur = mk(8'h0E, 1'b1, ALU_MUL, 8'd7, 8'd6, 3'd1, 3'd2, 3'd3);
    set_id(cur);
    step();
    Flush_EX = 1'b0;
    settle();
    chk_bubble("stall_flush");
    step();
    // cur MUL in E0; reset at E3.
    step(); step(); step();
    settle();
    chk("reset_e3 stall_before", Stall_EX, 1);
    reset = 1'b1;
    cur = mk(8'h0F, 1'b1, ALU_SLL, 8'h81, 8'h07, 3'd1, 3'd2, 3'd3);
    set_id(cur);
    step();
    reset = 1'b0;
    settle();
    chk_bubble("reset_mid_mul");
    step();
    nxt = rnd_instr();
    set_id(nxt);
    run_ex(cur, 1'b0, 3'd0, 8'd0, "sll_81_7");

    // Randomized stream with random forwarding.
    for (int n = 0; n < 40; n++) begin
      cur = nxt;
      nxt = rnd_instr();
      set_id(nxt);
      mode = $urandom_range(0, 3);
      wwr = (mode == 1) ? cur.r1 : (mode == 2) ? cur.r2 : 3'($urandom);
      run_ex(cur, (mode == 1 || mode == 2) ? 1'b1 : (mode == 3 ? 1'($urandom) : 1'b0),
             wwr, 8'($urandom), $sformatf("rand%0d_op%0d", n, cur.op));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
